// File: rtl/data_mem_controller.sv
// -----------------------------------------------------------------------------
// data_mem_controller
//
// Bridges the EX/MEM stage's zero-latency data-memory view (req_* in, rsp_rd /
// rsp_stall out) to a synchronous single-port block RAM with a fixed read
// latency. Loads stall the pipeline until RAM data returns. Stores are posted
// into a one-entry write buffer and retire without stalling. A load whose word
// address matches the buffered store is served straight from the buffer.
//
// Ports
//   clock      in   1    single clock, all state on posedge
//   reset      in   1    asynchronous, active-low reset
//   req_en     in   1    access request (load or store)
//   req_we     in   1    1 = store, 0 = load; valid when req_en
//   req_addr   in   32   word address (bits above RAM_ADDR_WIDTH ignored)
//   req_wd     in   32   store data
//   rsp_rd     out  32   load data, valid when a load has req_en=1, rsp_stall=0
//   rsp_stall  out  1    combinational pipeline hold
//   ram_en     out  1    RAM port enable
//   ram_we     out  1    RAM write enable
//   ram_addr   out  RAM_ADDR_WIDTH  RAM word address
//   ram_wd     out  32   RAM write data
//   ram_rd     in   32   RAM read data, READ_LATENCY cycles after issue
//
// Parameters
//   RAM_ADDR_WIDTH  word-address bits driven to the RAM
//   READ_LATENCY    cycles from a read issue to valid ram_rd (1..15)
// -----------------------------------------------------------------------------
module data_mem_controller #(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int READ_LATENCY   = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req_en,
   input  logic                      req_we,
   input  logic [31:0]               req_addr,
   input  logic [31:0]               req_wd,
   output logic [31:0]               rsp_rd,
   output logic                      rsp_stall,
   output logic                      ram_en,
   output logic                      ram_we,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]               ram_wd,
   input  logic [31:0]               ram_rd
);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t                    r_state;
   logic [3:0]                r_cnt;
   logic                      r_wb_valid;
   logic [RAM_ADDR_WIDTH-1:0] r_wb_addr;
   logic [31:0]               r_wb_data;

   logic [RAM_ADDR_WIDTH-1:0] w_req_addr;
   logic                      w_hit;
   logic                      w_issue_read;
   logic                      w_drain;
   logic                      w_take_store;
   logic                      w_unused_addr_bits;

   assign w_req_addr         = req_addr[RAM_ADDR_WIDTH-1:0];
   assign w_unused_addr_bits = &{1'b0, req_addr[31:RAM_ADDR_WIDTH]};
   assign w_hit              = r_wb_valid && (r_wb_addr == w_req_addr);

   // Request decode and RAM port arbitration. A read issue always wins the
   // port; otherwise a valid buffer entry drains whenever nothing else needs it.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      rsp_stall    = 1'b0;
      rsp_rd       = '0;
      ram_en       = 1'b0;
      ram_we       = 1'b0;
      ram_addr     = '0;
      ram_wd       = '0;
      w_issue_read = 1'b0;
      w_drain      = 1'b0;
      w_take_store = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (req_en) begin
               if (req_we) begin
                  // Old entry (if any) drains while the new store replaces it.
                  w_take_store = 1'b1;
                  w_drain      = r_wb_valid;
               end else if (w_hit) begin
                  // Forward from the buffer; the entry stays put.
                  rsp_rd = r_wb_data;
               end else if (r_wb_valid) begin
                  // Clear the buffer first so the load later sees RAM current.
                  rsp_stall = 1'b1;
                  w_drain   = 1'b1;
               end else begin
                  rsp_stall    = 1'b1;
                  w_issue_read = 1'b1;
               end
            end else begin
               w_drain = r_wb_valid;
            end
         end
         ST_WAIT: begin
            w_drain = r_wb_valid;
            if (r_cnt != 4'd0) begin
               rsp_stall = 1'b1;
            end else begin
               rsp_rd = ram_rd;
            end
         end
         default: ;
      endcase

      if (w_issue_read) begin
         ram_en   = 1'b1;
         ram_addr = w_req_addr;
      end else if (w_drain) begin
         ram_en   = 1'b1;
         ram_we   = 1'b1;
         ram_addr = r_wb_addr;
         ram_wd   = r_wb_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 4'd0;
         r_wb_valid <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_data  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register update reading
         // the pre-edge values, independent of statement order.
         case (r_state)
            ST_IDLE: begin
               if (w_issue_read) begin
                  r_state <= ST_WAIT;
                  r_cnt   <= 4'(READ_LATENCY - 1);
               end
            end
            ST_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_take_store) begin
            r_wb_valid <= 1'b1;
            r_wb_addr  <= w_req_addr;
            r_wb_data  <= req_wd;
         end else if (w_drain) begin
            r_wb_valid <= 1'b0;
         end
      end
   end

endmodule
